// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with a small TX FIFO
// Revision 1.0
// ============================================================================
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        sel,
   output logic        tx,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [7:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            full, empty, push_req, push, pop, ovf, wr_sel, bit_end;
   logic [1:0]      reg_idx;
   logic [15:0]     div, frame_div, frame_div_n, cyc, cyc_n;
   logic [2:0]      bit_idx, bit_idx_n;
   logic [7:0]      shift, shift_n;
   logic            unused_bits;

   assign sel      = (a[31:4] == BASE_ADDR[31:4]);
   assign reg_idx  = a[3:2];
   assign wr_sel   = we && sel;
   assign full     = (count == CW'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign push_req = wr_sel && (reg_idx == 2'd0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push     = push_req && (!full || pop);
   assign irq      = empty && (state == IDLE);
   assign bit_end  = (cyc == frame_div - 16'd1);
   assign unused_bits = &{1'b0, wd[31:16], a[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= wd[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
         div <= DIV_RESET;
      end else begin
         if (push_req && full && !pop)                  ovf <= 1'b1;
         else if (wr_sel && (reg_idx == 2'd1) && wd[3]) ovf <= 1'b0;
         if (wr_sel && (reg_idx == 2'd2))
            div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cyc       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         frame_div <= DIV_RESET;
      end else begin
         state     <= state_n;
         cyc       <= cyc_n;
         bit_idx   <= bit_idx_n;
         shift     <= shift_n;
         frame_div <= frame_div_n;
      end
   end

   always_comb begin
      state_n     = state;
      cyc_n       = cyc;
      bit_idx_n   = bit_idx;
      shift_n     = shift;
      frame_div_n = frame_div;
      pop         = 1'b0;
      tx          = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop         = 1'b1;
               shift_n     = fifo_mem[rd_ptr];
               frame_div_n = div;
               cyc_n       = '0;
               state_n     = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (bit_end) begin
               cyc_n     = '0;
               bit_idx_n = '0;
               state_n   = DATA;
            end else begin
               cyc_n = cyc + 16'd1;
            end
         end
         DATA: begin
            tx = shift[0];
            if (bit_end) begin
               cyc_n     = '0;
               shift_n   = {1'b0, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end else begin
               cyc_n = cyc + 16'd1;
            end
         end
         STOP: begin
            tx = 1'b1;
            if (bit_end) begin
               cyc_n = '0;
               // Chain straight into the next frame when data is waiting.
               if (!empty) begin
                  pop         = 1'b1;
                  shift_n     = fifo_mem[rd_ptr];
                  frame_div_n = div;
                  state_n     = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cyc_n = cyc + 16'd1;
            end
         end
      endcase
   end

   always_comb begin
      rd = '0;
      if (sel) begin
         case (reg_idx)
            2'd1:    rd = {16'h0000, 8'(count), 4'h0, ovf, empty, full, (state != IDLE)};
            2'd2:    rd = {16'h0000, div};
            default: rd = '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_mmio_uart_tx : self-checking bench for mmio_uart_tx
// Revision 1.0
// ============================================================================
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        sel;
   logic        tx;
   logic        irq;

   mmio_uart_tx #(
      .BASE_ADDR (BASE),
      .FIFO_DEPTH(4),
      .DIV_RESET (16'd16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .we   (we),
      .a    (a),
      .wd   (wd),
      .rd   (rd),
      .sel  (sel),
      .tx   (tx),
      .irq  (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         div;
   } frame_t;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic        exp_sel;
      string       name;
   } vec_t;

   frame_t exp_q[$];
   vec_t   vecs[14];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     frames_done = 0;
   int     last_start = 0;
   int     prev_start = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Serial-line monitor: pops the expected frame at each start bit and checks every bit period.
   frame_t cur;
   bit     m_active = 1'b0;
   bit     m_bad;
   int     m_bit, m_cnt;
   logic   exp_bit;

   always @(negedge clk) begin
      if (reset) begin
         m_active = 1'b0;
      end else begin
         if (!m_active && tx == 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got start bit at cycle %0d, expected idle line", cyc);
            end else begin
               cur        = exp_q.pop_front();
               m_active   = 1'b1;
               m_bit      = 0;
               m_cnt      = 0;
               m_bad      = 1'b0;
               prev_start = last_start;
               last_start = cyc;
            end
         end
         if (m_active) begin
            exp_bit = (m_bit == 0) ? 1'b0 : (m_bit == 9) ? 1'b1 : cur.data[m_bit-1];
            if (tx !== exp_bit) m_bad = 1'b1;
            m_cnt++;
            if (m_cnt == cur.div) begin
               checks++;
               if (m_bad) begin
                  errors++;
                  $display("FAIL frame_bit: byte 0x%02h bit %0d got wrong level, expected %0b for %0d cycles",
                           cur.data, m_bit, exp_bit, cur.div);
               end
               m_bit++;
               m_cnt = 0;
               m_bad = 1'b0;
               if (m_bit == 10) begin
                  m_active = 1'b0;
                  frames_done++;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic rdreg(input logic [31:0] addr, output logic [31:0] v);
      we = 1'b0;
      a  = addr;
      #1;
      v = rd;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int k);
      a  = addr;
      wd = data;
      we = 1'b1;
      @(posedge clk);
      #1;
      k  = cyc;
      we = 1'b0;
      @(negedge clk);
      #2;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int i;
      i = 0;
      while (frames_done < n && i < budget) begin
         @(negedge clk);
         #2;
         i++;
      end
      checks++;
      if (frames_done < n) begin
         errors++;
         $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, n);
      end
   endtask

   task automatic wait_cycle(input int target, input int budget);
      int i;
      i = 0;
      while (cyc < target && i < budget) begin
         @(negedge clk);
         #2;
         i++;
      end
      checks++;
      if (cyc != target) begin
         errors++;
         $display("FAIL cycle_wait: got cycle %0d expected %0d", cyc, target);
      end
   endtask

   initial begin
      logic [31:0] v;
      int          k, k1, s1, snap;

      vecs[0]  = '{1'b0, BASE + 32'h4,  32'h0,          32'h0000_0004, 1'b1, "status_reset"};
      vecs[1]  = '{1'b0, BASE + 32'h8,  32'h0,          32'h0000_0010, 1'b1, "div_reset"};
      vecs[2]  = '{1'b0, BASE + 32'h0,  32'h0,          32'h0000_0000, 1'b1, "data_read"};
      vecs[3]  = '{1'b0, BASE + 32'hC,  32'h0,          32'h0000_0000, 1'b1, "reserved_read"};
      vecs[4]  = '{1'b0, BASE + 32'h10, 32'h0,          32'h0000_0000, 1'b0, "outside_read"};
      vecs[5]  = '{1'b1, BASE + 32'h18, 32'h0000_0003,  32'h0000_0000, 1'b0, "outside_write"};
      vecs[6]  = '{1'b0, BASE + 32'h8,  32'h0,          32'h0000_0010, 1'b1, "div_after_outside"};
      vecs[7]  = '{1'b1, BASE + 32'h8,  32'h0,          32'h0000_0010, 1'b1, "div_write_zero"};
      vecs[8]  = '{1'b0, BASE + 32'h8,  32'h0,          32'h0000_0001, 1'b1, "div_zero_clamp"};
      vecs[9]  = '{1'b1, BASE + 32'hB,  32'h0001_2345,  32'h0000_0001, 1'b1, "div_write_low_bits"};
      vecs[10] = '{1'b0, BASE + 32'h8,  32'h0,          32'h0000_2345, 1'b1, "div_readback"};
      vecs[11] = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF,  32'h0000_0000, 1'b1, "reserved_write"};
      vecs[12] = '{1'b0, BASE + 32'h4,  32'h0,          32'h0000_0004, 1'b1, "status_after_reserved"};
      vecs[13] = '{1'b0, 32'h0000_0204, 32'h0,          32'h0000_0000, 1'b0, "near_miss"};

      reset = 1'b1;
      we    = 1'b0;
      a     = 32'h0;
      wd    = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_tx", {31'h0, tx}, 32'h1);
      chk("reset_irq", {31'h0, irq}, 32'h1);
      reset = 1'b0;
      #2;

      // Register map vectors
      for (int i = 0; i < 14; i++) begin
         a  = vecs[i].addr;
         wd = vecs[i].data;
         we = vecs[i].w;
         #1;
         chk({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
         chk({vecs[i].name, "_sel"}, {31'h0, sel}, {31'h0, vecs[i].exp_sel});
         @(posedge clk);
         #1;
         we = 1'b0;
         @(negedge clk);
         #2;
      end

      // Single frame, div 4, including first-pop latency
      wr(BASE + 32'h8, 32'd4, k);
      exp_q.push_back('{8'h55, 4});
      wr(BASE + 32'h0, 32'h55, k);
      chk("t1_tx_before_pop", {31'h0, tx}, 32'h1);
      rdreg(BASE + 32'h4, v);
      chk("t1_status_queued", v, 32'h0000_0100);
      @(negedge clk);
      #2;
      chk("t1_tx_start", {31'h0, tx}, 32'h0);
      chk("t1_irq_busy", {31'h0, irq}, 32'h0);
      rdreg(BASE + 32'h4, v);
      chk("t1_status_busy", v, 32'h0000_0005);
      chk("t1_start_cycle", last_start, k + 1);
      wait_frames(1, 60);
      @(negedge clk);
      #2;
      chk("t1_irq_idle", {31'h0, irq}, 32'h1);
      rdreg(BASE + 32'h4, v);
      chk("t1_status_idle", v, 32'h0000_0004);

      // Back-to-back frames, no idle gap
      wr(BASE + 32'h8, 32'd2, k);
      exp_q.push_back('{8'hA1, 2});
      exp_q.push_back('{8'h3C, 2});
      wr(BASE + 32'h0, 32'hA1, k1);
      wr(BASE + 32'h0, 32'h3C, k);
      wait_frames(3, 100);
      chk("t2_first_start", prev_start, k1 + 1);
      chk("t2_no_gap", last_start - prev_start, 32'd20);
      @(negedge clk);
      #2;
      chk("t2_irq_idle", {31'h0, irq}, 32'h1);

      // Overflow, W1C, and push+pop while full
      exp_q.push_back('{8'h11, 2});
      wr(BASE + 32'h0, 32'h11, k);
      @(negedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{8'h22 + 8'(i * 8'h11), 2});
         wr(BASE + 32'h0, 32'h22 + i * 32'h11, k1);
      end
      wr(BASE + 32'h0, 32'h66, k1);
      rdreg(BASE + 32'h4, v);
      chk("t3_status_full_ovf", v, 32'h0000_040B);
      wr(BASE + 32'h4, 32'h0000_0008, k1);
      rdreg(BASE + 32'h4, v);
      chk("t3_status_ovf_clear", v, 32'h0000_0403);
      s1 = last_start;
      chk("t3_frame_start", s1, k + 1);
      wait_cycle(s1 + 19, 40);
      exp_q.push_back('{8'h77, 2});
      wr(BASE + 32'h0, 32'h77, k1);
      chk("t3_pushpop_cycle", k1, s1 + 20);
      rdreg(BASE + 32'h4, v);
      chk("t3_status_pushpop", v, 32'h0000_0403);
      wait_frames(9, 180);

      // Divisor clamp and mid-frame divisor change
      wr(BASE + 32'h8, 32'd0, k);
      rdreg(BASE + 32'h8, v);
      chk("t4_div_clamp", v, 32'h0000_0001);
      wr(BASE + 32'h8, 32'd2, k);
      exp_q.push_back('{8'h0F, 2});
      exp_q.push_back('{8'hF0, 8});
      wr(BASE + 32'h0, 32'h0F, k);
      wr(BASE + 32'h0, 32'hF0, k);
      wr(BASE + 32'h8, 32'd8, k);
      rdreg(BASE + 32'h8, v);
      chk("t4_div_new", v, 32'h0000_0008);
      wait_frames(11, 160);
      chk("t4_first_frame_len", last_start - prev_start, 32'd20);

      // Asynchronous reset in the middle of a data bit with bytes queued
      wr(BASE + 32'h8, 32'd4, k);
      exp_q.push_back('{8'h5A, 4});
      wr(BASE + 32'h0, 32'h5A, k);
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back('{8'(i), 4});
         wr(BASE + 32'h0, 32'(i), k1);
      end
      wait_cycle(k + 18, 40);
      @(posedge clk);
      #3;
      reset = 1'b1;
      exp_q.delete();
      snap = frames_done;
      #1;
      chk("t5_tx_reset", {31'h0, tx}, 32'h1);
      chk("t5_irq_reset", {31'h0, irq}, 32'h1);
      rdreg(BASE + 32'h4, v);
      chk("t5_status_reset", v, 32'h0000_0004);
      rdreg(BASE + 32'h8, v);
      chk("t5_div_reset", v, 32'h0000_0010);
      @(negedge clk);
      reset = 1'b0;
      #2;
      repeat (100) @(negedge clk);
      #2;
      chk("t5_no_more_frames", frames_done, snap);
      chk("t5_tx_idle", {31'h0, tx}, 32'h1);

      chk("final_queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
